reg_file_param: RTL
===================

// Module: reg_file_param
// PURPOSE
//  Parametrised multi-read-port register file for the CPU datapath; generalises the 32x32, 2-read/1-write file.
//  Adds configurable width/depth/read-port count, a hardwired-zero entry and a sequential clear engine.
//  The clear engine runs after reset and on request, with a busy flag the pipeline stalls on.
//  Sits between decode (read addresses) and writeback (write port).
// PARAMETERS
//  DATA_W    32  bits per register
//  ADDR_W    5   address bits; DEPTH = 2**ADDR_W entries
//  NUM_RD    2   number of independent read ports (1..4)
//  ZERO_REG  1   1: entry 0 always reads 0 and writes to it are dropped; 0: entry 0 is ordinary
// PORTS
//  clk_i      in   1              clock, all state on rising edge
//  rst_n_i    in   1              asynchronous active-low reset
//  rd_addr_i  in   NUM_RD*ADDR_W  read addresses; port k = bits [k*ADDR_W +: ADDR_W]
//  rd_data_o  out  NUM_RD*DATA_W  read data; port k = bits [k*DATA_W +: DATA_W], combinational
//  wr_en_i    in   1              write enable
//  wr_addr_i  in   ADDR_W         write address
//  wr_data_i  in   DATA_W         write data
//  clr_i      in   1              request full clear (1-cycle pulse sufficient)
//  busy_o     out  1              clear sequence in progress; writes ignored, reads return 0
// BEHAVIOUR
//  - Reset (rst_n_i=0, async): FSM -> CLEAR, clr_cnt -> 0, busy_o -> 1. Storage array itself not async-reset.
//  - FSM states: CLEAR, IDLE.
//    CLEAR: each cycle write 0 to entry clr_cnt and increment it; when clr_cnt==DEPTH-1, that cycle writes the
//    last entry and FSM -> IDLE, clr_cnt -> 0. Clear takes exactly DEPTH cycles after reset deassertion.
//    IDLE: clr_i=1 -> CLEAR next cycle; busy_o=1 from that next cycle.
//  - busy_o = (state==CLEAR), registered-state decode, no glitch path from inputs.
//  - Write in IDLE: wr_en_i=1 stores wr_data_i at wr_addr_i on the rising edge. Visible on reads the following cycle
//    unless bypass is enabled (see CONFIGURATION).
//    ZERO_REG=1 and wr_addr_i==0: write dropped.
//  - Write in CLEAR: ignored, even at addresses already cleared. clr_i in CLEAR: ignored, the count is not restarted.
//  - Same-cycle wr_en_i and clr_i in IDLE: the write is performed; the clear then zeroes it. Result: all entries 0.
//  - Reads: rd_data_o[k] = 0 if busy_o, or if ZERO_REG and addr==0; else the stored entry.
//    Ports are independent; identical addresses on several ports are legal.
//  - Reset asserted mid-clear or mid-write: FSM restarts CLEAR at clr_cnt=0; the interrupted write may be lost.
//  - clr_cnt width ADDR_W; the terminal compare must not rely on wrap-around.
// CONFIGURATION
//  RF_WRITE_BYPASS_EN defined:
//    In IDLE, when wr_en_i=1, the write is not dropped (not ZERO_REG with addr 0) and rd_addr_i[k]==wr_addr_i,
//    rd_data_o[k] = wr_data_i in the same cycle. This is write-through forwarding for the pipeline.
//  RF_WRITE_BYPASS_EN undefined: same-cycle reads return the old stored value; the new value appears next cycle.
//  Zero and busy forcing take priority over bypass in both builds.
// STRUCTURE
//  Package reg_file_pkg:
//    - rf_state_t enum {RF_CLEAR, RF_IDLE}
//    - localparam function rf_depth(ADDR_W) = 1<<ADDR_W
//  Sub-module reg_file_clear_fsm: state, clr_cnt, busy_o and the clear-write strobe/address.
//  Top level: storage array, write-port mux (clear vs user), NUM_RD read muxes via generate loop.
// TESTING
//  1 Reset release, ADDR_W=5: busy_o=1 for exactly 32 cycles, then 0; all ports read 0 while busy.
//    After busy, read all 32 entries -> 0.
//  2 Write 0xDEADBEEF to r7, then read r7 on all NUM_RD ports next cycle -> 0xDEADBEEF.
//    Write 0x1234 to r0 -> r0 reads 0 (ZERO_REG=1); with ZERO_REG=0 -> 0x1234.
//  3 Same-cycle write r5=0xA5A5A5A5 and read r5: bypass build -> 0xA5A5A5A5 that cycle;
//    non-bypass build -> old value, 0xA5A5A5A5 next cycle.
//  4 Fill r1..r31 with index values, pulse clr_i: busy_o high the next cycle for 32 cycles.
//    Writes issued during busy are ignored; afterwards all entries read 0.
//  5 Simultaneous clr_i and write r3=0xFF in IDLE: after the clear completes, r3 reads 0.
//  6 Assert rst_n_i at clr_cnt=10 during a clear: busy_o stays 1, clear restarts,
//    completes 32 cycles after reset deassertion.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the parametrised register file.
package reg_file_pkg;

    typedef enum logic {RF_CLEAR, RF_IDLE} rf_state_t;

    function automatic int rf_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/reg_file_clear_fsm.sv
// Sequential clear engine: walks every entry after reset or on request, raising busy_o meanwhile.
module reg_file_clear_fsm
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clr_i,
    output logic              busy_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(rf_depth(ADDR_W) - 1);

    rf_state_t         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= RF_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Terminal compare against the last index; the counter never relies on wrapping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RF_CLEAR: begin
                if (cnt_q == LAST) begin
                    state_d = RF_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            RF_IDLE: begin
                if (clr_i) state_d = RF_CLEAR;
            end
            default: state_d = RF_CLEAR;
        endcase
    end

    assign busy_o     = (state_q == RF_CLEAR);
    assign clr_we_o   = busy_o;
    assign clr_addr_o = cnt_q;

endmodule

// File: rtl/reg_file_param.sv
// Multi-read-port register file with optional hardwired-zero entry and a clear engine.
// Define RF_WRITE_BYPASS_EN to forward same-cycle writes to matching read ports.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    input  logic                     wr_en_i,
    input  logic [ADDR_W-1:0]        wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     clr_i,
    output logic                     busy_o
);

    localparam int DEPTH = rf_depth(ADDR_W);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_ok;

    reg_file_clear_fsm #(.ADDR_W(ADDR_W)) u_clr (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .clr_i      (clr_i),
        .busy_o     (busy),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    assign busy_o = busy;
    assign wr_ok  = !busy && wr_en_i && !((ZERO_REG != 0) && (wr_addr_i == '0));

    // Storage has no reset; the clear engine zeroes it after every reset.
    always_ff @(posedge clk_i) begin
        if (clr_we)     mem_q[clr_addr]  <= '0;
        else if (wr_ok) mem_q[wr_addr_i] <= wr_data_i;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;

        assign a = rd_addr_i[k*ADDR_W +: ADDR_W];

        // Zero and busy forcing are applied last so they win over forwarding.
        always_comb begin
            d = mem_q[a];
`ifdef RF_WRITE_BYPASS_EN
            if (wr_ok && (a == wr_addr_i)) d = wr_data_i;
`endif
            if (busy || ((ZERO_REG != 0) && (a == '0))) d = '0;
        end

        assign rd_data_o[k*DATA_W +: DATA_W] = d;
    end

endmodule
